// File: rtl/pipe_chain.sv
// Elastic register chain: DEPTH valid/ready stages with bubble collapse and flush.
// Optional occupancy output o_count is built only when PIPE_CHAIN_COUNT_EN is defined.
module pipe_chain #(
  parameter int W_DATA = 32,
  parameter int DEPTH  = 4,
  parameter int W_CNT  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [W_DATA-1:0] o_data
`ifdef PIPE_CHAIN_COUNT_EN
  ,
  output logic [W_CNT-1:0]  o_count
`endif
);

  // Handshake: a word moves across a boundary on a rising edge where the sender's
  // valid and the receiver's ready are both 1; valid never waits on ready, and a
  // sender holding valid keeps its data stable until the transfer happens.

  if (W_DATA < 1 || W_DATA > 256) begin : g_bad_width
    $error("pipe_chain: W_DATA out of range");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("pipe_chain: DEPTH out of range");
  end
  if (W_CNT < $clog2(DEPTH + 1)) begin : g_bad_cnt
    $error("pipe_chain: W_CNT too narrow for DEPTH");
  end

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  v_d;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  load;
  logic [W_DATA-1:0] data_q [DEPTH];

  // A stage advances unless every stage above it is full and downstream stalls;
  // this is the long ready path that lets o_ready follow i_ready in one cycle.
  always_comb begin
    logic blocked;
    blocked = ~i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]  = v_q[k] & ~blocked;
      blocked = blocked & v_q[k];
    end
  end

  always_comb begin
    load    = '0;
    load[0] = i_valid & (~v_q[0] | adv[0]);
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = v_q[k-1] & (~v_q[k] | adv[k]);
    end
    v_d = load | (v_q & ~adv);
  end

  always_ff @(posedge i_clk) begin
    if (reset || i_flush) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // Data registers carry no reset and only capture when a word lands in them.
  always_ff @(posedge i_clk) begin
    if (load[0]) begin
      data_q[0] <= i_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (load[k]) begin
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign o_ready = ~v_q[0] | adv[0];
  assign o_valid = v_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];

`ifdef PIPE_CHAIN_COUNT_EN
  logic [W_CNT-1:0] cnt_q;

  function automatic logic [W_CNT-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [W_CNT-1:0] n;
    n = '0;
    for (int k = 0; k < DEPTH; k++) begin
      n = n + W_CNT'(bits[k]);
    end
    return n;
  endfunction

  always_ff @(posedge i_clk) begin
    if (reset || i_flush) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= popcount(v_d);
    end
  end

  assign o_count = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain (DEPTH=4): directed scenarios plus random
// valid/ready/flush stress against a word-position reference model.
module tb_pipe_chain;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int WC = $clog2(D + 1);

  logic         i_clk = 1'b0;
  logic         reset;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic         i_flush;
  logic [W-1:0] o_data;
`ifdef PIPE_CHAIN_COUNT_EN
  logic [WC-1:0] o_count;
`endif

  pipe_chain #(.W_DATA(W), .DEPTH(D)) dut (
    .i_clk   (i_clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .i_flush (i_flush),
    .o_data  (o_data)
`ifdef PIPE_CHAIN_COUNT_EN
    ,
    .o_count (o_count)
`endif
  );

  // Clock / reset block
  always #5 i_clk = ~i_clk;

  // Scoreboard: words held by the chain (oldest first) and the stage each occupies
  logic [W-1:0] exp_q[$];
  int           pos_q[$];
  int           np_q[$];
  bit           drop_head;
  logic [W-1:0] out_q[$];

  int n_cmp = 0;
  int n_err = 0;

  bit           s_valid, s_ready, acc;
  logic [W-1:0] s_data;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every word slides one stage per cycle toward the output but cannot pass or
  // share a stage with the word ahead; the head leaves when at the last stage
  // and downstream is ready. Returns whether stage 0 is free after that motion.
  function automatic bit model_move(input bit rdy);
    int lim;
    int np;
    np_q      = {};
    drop_head = 1'b0;
    lim       = D;
    for (int i = 0; i < pos_q.size(); i++) begin
      if (i == 0 && pos_q[0] == D - 1 && rdy) begin
        drop_head = 1'b1;
      end else begin
        np  = (pos_q[i] + 1 < lim - 1) ? pos_q[i] + 1 : lim - 1;
        np_q.push_back(np);
        lim = np;
      end
    end
    return (np_q.size() == 0) || (np_q[np_q.size()-1] > 0);
  endfunction

  // Driver: one clock cycle of stimulus, checks on the settled outputs, then model update.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r,
                       input bit f, input bit rs, input bit chk);
    bit rdy_m;
    bit vld_m;
    @(negedge i_clk);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
    reset   = rs;
    #1;
    s_valid = o_valid;
    s_ready = o_ready;
    s_data  = o_data;
    rdy_m   = model_move(r);
    vld_m   = (pos_q.size() > 0) && (pos_q[0] == D - 1);
    if (chk) begin
      check_eq("o_valid", W'(o_valid), W'(vld_m));
      check_eq("o_ready", W'(o_ready), W'(rdy_m));
      if (vld_m) check_eq("o_data", o_data, exp_q[0]);
`ifdef PIPE_CHAIN_COUNT_EN
      check_eq("o_count", W'(o_count), W'(pos_q.size()));
`endif
      if (o_valid && r) out_q.push_back(o_data);
    end
    acc = v && rdy_m;
    @(posedge i_clk);
    if (rs || f) begin
      exp_q = {};
      pos_q = {};
    end else begin
      if (drop_head) void'(exp_q.pop_front());
      pos_q = np_q;
      if (acc) begin
        exp_q.push_back(d);
        pos_q.push_back(0);
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q = {};
    pos_q = {};
    out_q = {};
  endtask

  initial begin
    int lat;
    int nval;
    int nacc;
    int nlow;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    reset   = 1'b1;

    // Reset state
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("rst_o_valid", W'(s_valid), W'(0));
    check_eq("rst_o_ready", W'(s_ready), W'(1));

    // Single word latency through an empty chain
    cycle(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("lat_accept", W'(acc), W'(1));
    lat  = 0;
    nval = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (s_valid) begin
        nval++;
        if (lat == 0) lat = i;
        check_eq("lat_data", s_data, 32'hA5A5_A5A5);
      end
    end
    check_eq("lat_cycles", W'(lat), W'(4));
    check_eq("lat_width", W'(nval), W'(1));

    // Streaming 1..100
    do_reset();
    nlow = 0;
    for (int i = 1; i <= 100; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      if (!s_ready) nlow++;
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("stream_ready_low", W'(nlow), W'(0));
    check_eq("stream_count", W'(out_q.size()), W'(100));
    for (int i = 0; i < out_q.size(); i++) check_eq("stream_order", out_q[i], W'(i + 1));

    // Backpressure: 6 pushes, 4 accepted, release
    do_reset();
    nacc = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      if (acc) nacc++;
    end
    check_eq("bp_accepted", W'(nacc), W'(4));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("bp_ready_low", W'(s_ready), W'(0));
`ifdef PIPE_CHAIN_COUNT_EN
    check_eq("bp_count", W'(o_count), W'(4));
`endif
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("bp_ready_release", W'(s_ready), W'(1));
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("bp_out_count", W'(out_q.size()), W'(4));
    for (int i = 0; i < out_q.size(); i++) check_eq("bp_order", out_q[i], W'(i + 1));

    // Bubble collapse: 2 words stall at the output end
    do_reset();
    cycle(1'b1, W'(11), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, W'(12), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("bub_ready", W'(s_ready), W'(1));
    check_eq("bub_head", s_data, W'(11));
    check_eq("bub_pos", W'((pos_q.size() == 2) && pos_q[0] == 3 && pos_q[1] == 2), W'(1));

    // Flush with concurrent transfer-in
    do_reset();
    for (int i = 1; i <= 3; i++) cycle(1'b1, W'(20 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("flush_valid", W'(s_valid), W'(0));
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("flush_no_out", W'(out_q.size()), W'(0));

    // Reset with full chain and flush, then random stress
    for (int i = 1; i <= 5; i++) cycle(1'b1, W'(30 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, W'(99), 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_full_valid", W'(s_valid), W'(0));
    check_eq("rst_full_ready", W'(s_ready), W'(1));
    for (int i = 0; i < 3000; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), W'($urandom), bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 99) == 0), bit'($urandom_range(0, 299) == 0), 1'b1);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("stress_drained", W'(s_valid), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 The block SHALL have parameter W_DATA, default 32, meaning payload width in bits (1..256).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of register stages (1..16).
REQ-003 The block SHALL have parameter W_CNT, default $clog2(DEPTH+1), meaning occupancy count width.
REQ-004 Port i_clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, meaning reset; it SHALL be synchronous and active-high.
REQ-006 Port i_valid, input, 1, meaning upstream offers i_data.
REQ-007 Port o_ready, output, 1, meaning block accepts i_data this cycle.
REQ-008 Port i_data, input, W_DATA, meaning upstream payload.
REQ-009 Port o_valid, output, 1, meaning last stage holds a valid word.
REQ-010 Port i_ready, input, 1, meaning downstream accepts o_data this cycle.
REQ-011 Port o_data, output, W_DATA, meaning last-stage payload.
REQ-012 Port i_flush, input, 1, meaning discard all held words.
REQ-013 Port o_count, output, W_CNT, meaning number of valid stages (present only per REQ-027).

Function
REQ-014 Stage k (0 = input, DEPTH-1 = output) SHALL hold a valid bit v[k] and a W_DATA data register.
REQ-015 Stage k SHALL advance when v[k]=1 and (k=DEPTH-1 ? i_ready : v[k+1]=0 or stage k+1 advances).
REQ-016 Stage k SHALL load from stage k-1 (stage 0 from i_data) when it is empty or advancing, and the source is valid; otherwise v[k] clears when it advances.
REQ-017 o_ready SHALL equal (v[0]=0 or stage 0 advances), combinationally; transfer-in occurs when i_valid and o_ready.
REQ-018 Bubbles SHALL collapse: any empty stage SHALL be filled the cycle its predecessor is valid, independent of i_ready.
REQ-019 Latency through an empty chain SHALL be exactly DEPTH cycles from transfer-in to o_valid=1.
REQ-020 Sustained throughput SHALL be one word per cycle when i_valid=1 and i_ready=1; no words dropped, duplicated or reordered.
REQ-021 o_valid SHALL equal v[DEPTH-1]; o_data SHALL equal last-stage data and remain stable while o_valid=1 and i_ready=0.
REQ-022 Data registers of empty stages SHALL NOT load (power); their contents are don't-care.
REQ-023 i_flush=1 SHALL clear all v[k] at the next edge; a word transferred-in that same cycle SHALL be discarded; o_ready is unaffected by i_flush.
REQ-024 Full chain with i_ready=0: o_ready=0; if i_ready rises, o_ready=1 in the same cycle (combinational path through DEPTH stages).

Reset
REQ-025 When reset=1 at a rising edge, all v[k] SHALL clear; o_valid=0, o_count=0, o_ready=1 from the next cycle; data registers are not reset.
REQ-026 reset SHALL take priority over i_flush and any transfer; words in flight mid-operation are lost.

Configuration
REQ-027 Macro PIPE_CHAIN_COUNT_EN: when defined, o_count SHALL exist and equal the population count of v[], registered-equivalent (valid the cycle after the edge updating v[]); when undefined, the o_count port and its logic SHALL be absent and behaviour otherwise identical.

Verification
REQ-028 DEPTH=4, reset, then i_valid=1 with 0xA5A5A5A5 one cycle, i_ready=1 -> o_valid=1 with o_data=0xA5A5A5A5 exactly 4 cycles after transfer-in, single cycle.
REQ-029 DEPTH=4, stream 1..100 with i_valid=i_ready=1 -> outputs 1..100 in order, one per cycle, o_ready constantly 1.
REQ-030 DEPTH=4, i_ready=0, push 6 words -> exactly 4 accepted, o_ready=0, o_count=4 (COUNT_EN); raise i_ready -> o_ready=1 same cycle, words 1..4 emerge in order.
REQ-031 DEPTH=4, i_ready=0, 2 words pushed then idle -> both collapse to stages 3 and 2, o_count=2; o_ready stays 1.
REQ-032 Chain holding 3 words, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_count=0, flushed and concurrent word never appear.
REQ-033 Reset asserted with full chain and i_flush=1 -> next cycle o_valid=0, o_ready=1, o_count=0; random valid/ready stress afterwards matches a scoreboard.
